// File: rtl/spart_link_if.sv
// spart_link_if: game-side word handshake and board-to-board serial pins of one spart link.
interface spart_link_if #(parameter int DATA_W = 24);
  logic              send_tx;
  logic [DATA_W-1:0] tx_data;
  logic              tx_full;
  logic              tx_drop;
  logic              tx_busy;
  logic              txd;
  logic              rxd;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_err;
  logic [1:0]        rx_err_code;
  modport master (output send_tx, tx_data, rxd,
                  input tx_full, tx_drop, tx_busy, txd, rx_valid, rx_data, rx_err, rx_err_code);
  modport slave  (input send_tx, tx_data, rxd,
                  output tx_full, tx_drop, tx_busy, txd, rx_valid, rx_data, rx_err, rx_err_code);
endinterface

// File: rtl/spart_link.sv
// spart_link: word-wide UART link, TX word FIFO + byte serialiser, RX deserialiser with error reporting.
module spart_link #(
  parameter int DATA_W       = 24,
  parameter int CLKS_PER_BIT = 16,
  parameter int TX_DEPTH     = 4,
  parameter int PARITY_EN    = 0,
  parameter int TIMEOUT_BITS = 20
) (
  input  logic         clk,
  input  logic         rst,
  spart_link_if.slave  s
);
  localparam int NBYTES = DATA_W / 8;
  localparam int BW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  localparam int AW = $clog2(TX_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int TMO = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int MW = $clog2(TMO + 1);
  localparam logic PEN = PARITY_EN != 0;
  localparam logic [BW-1:0] LAST = BW'(NBYTES - 1);
  localparam logic [CW-1:0] BIT_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_e;
  typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP, R_WAIT} rx_st_e;
  logic [DATA_W-1:0] mem_q [TX_DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0] cnt_q;
  logic tx_full, push, pop, tx_drop_q, tend;
  tx_st_e txs_q, txs_d;
  logic [CW-1:0] tcnt_q, tcnt_d;
  logic [2:0] tbit_q, tbit_d;
  logic [BW-1:0] tbyte_q, tbyte_d;
  logic [DATA_W-1:0] tsh_q, tsh_d;
  logic tpar_q, tpar_d, txd_q, txd_d;
  assign tx_full = cnt_q == (AW+1)'(TX_DEPTH);
  assign push = s.send_tx & ~tx_full;
  assign tend = tcnt_q == BIT_END;
  always_ff @(posedge clk) if (push) mem_q[wr_q] <= s.tx_data;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      tx_drop_q <= 1'b0;
    end else begin
      wr_q <= wr_q + AW'(push);
      rd_q <= rd_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      tx_drop_q <= s.send_tx & tx_full;
    end
  // The shift register holds the whole word; bytes leave LSB-first as it shifts right.
  always_comb begin
    txs_d = txs_q;
    tcnt_d = tend ? '0 : tcnt_q + 1'b1;
    tbit_d = tbit_q;
    tbyte_d = tbyte_q;
    tsh_d = tsh_q;
    tpar_d = tpar_q;
    pop = 1'b0;
    case (txs_q)
      T_IDLE: begin
        tcnt_d = '0;
        pop = cnt_q != '0;
      end
      T_START: begin
        tpar_d = 1'b0;
        if (tend) txs_d = T_DATA;
      end
      T_DATA: if (tend) begin
        tsh_d = tsh_q >> 1;
        tpar_d = tpar_q ^ tsh_q[0];
        tbit_d = tbit_q + 1'b1;
        if (tbit_q == 3'd7) txs_d = PEN ? T_PAR : T_STOP;
      end
      T_PAR: if (tend) txs_d = T_STOP;
      T_STOP: if (tend) begin
        tbyte_d = tbyte_q == LAST ? '0 : tbyte_q + 1'b1;
        pop = tbyte_q == LAST && cnt_q != '0;
        txs_d = tbyte_q == LAST && cnt_q == '0 ? T_IDLE : T_START;
      end
      default: txs_d = T_IDLE;
    endcase
    if (pop) begin
      tsh_d = mem_q[rd_q];
      tbyte_d = '0;
      txs_d = T_START;
    end
    txd_d = txs_d == T_START ? 1'b0 : txs_d == T_DATA ? tsh_d[0] : txs_d == T_PAR ? tpar_d : 1'b1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      txs_q <= T_IDLE;
      tcnt_q <= '0;
      tbit_q <= '0;
      tbyte_q <= '0;
      tsh_q <= '0;
      tpar_q <= 1'b0;
      txd_q <= 1'b1;
    end else begin
      txs_q <= txs_d;
      tcnt_q <= tcnt_d;
      tbit_q <= tbit_d;
      tbyte_q <= tbyte_d;
      tsh_q <= tsh_d;
      tpar_q <= tpar_d;
      txd_q <= txd_d;
    end
  assign s.tx_full = tx_full;
  assign s.tx_drop = tx_drop_q;
  assign s.tx_busy = cnt_q != '0 || txs_q != T_IDLE;
  assign s.txd = txd_q;
  logic r1_q, r2_q, r3_q;
  rx_st_e rxs_q, rxs_d;
  logic [CW-1:0] rcnt_q, rcnt_d;
  logic [2:0] rbit_q, rbit_d;
  logic [BW-1:0] rbyte_q, rbyte_d;
  logic [7:0] rsh_q, rsh_d;
  logic rpar_q, rpar_d, rvalid_q, rvalid_d, rerr_q, rerr_d;
  logic [1:0] rcode_q, rcode_d;
  logic [DATA_W-1:0] asm_q, asm_d, rdata_q, rdata_d;
  logic [MW-1:0] tmo_q, tmo_d;
  // r3_q is the previous synchronised level, used only for start-edge detection.
  always_comb begin
    rxs_d = rxs_q;
    rcnt_d = rcnt_q + 1'b1;
    rbit_d = rbit_q;
    rbyte_d = rbyte_q;
    rsh_d = rsh_q;
    rpar_d = rpar_q;
    asm_d = asm_q;
    rdata_d = rdata_q;
    rvalid_d = 1'b0;
    rerr_d = 1'b0;
    rcode_d = rcode_q;
    tmo_d = rxs_q == R_IDLE && rbyte_q != '0 ? tmo_q + 1'b1 : '0;
    case (rxs_q)
      R_IDLE: begin
        rcnt_d = '0;
        if (r3_q && !r2_q) begin
          rxs_d = R_START;
          tmo_d = '0;
        end else if (rbyte_q != '0 && tmo_q == MW'(TMO - 1)) begin
          rerr_d = 1'b1;
          rcode_d = 2'b11;
          rbyte_d = '0;
          tmo_d = '0;
        end
      end
      R_START: if (rcnt_q == HALF) begin
        rcnt_d = '0;
        rpar_d = 1'b0;
        rxs_d = r2_q ? R_IDLE : R_DATA;
      end
      R_DATA: if (rcnt_q == BIT_END) begin
        rcnt_d = '0;
        rsh_d = {r2_q, rsh_q[7:1]};
        rpar_d = rpar_q ^ r2_q;
        rbit_d = rbit_q + 1'b1;
        if (rbit_q == 3'd7) rxs_d = PEN ? R_PAR : R_STOP;
      end
      R_PAR: if (rcnt_q == BIT_END) begin
        rcnt_d = '0;
        rpar_d = rpar_q ^ r2_q;
        rxs_d = R_STOP;
      end
      R_STOP: if (rcnt_q == BIT_END) begin
        rxs_d = r2_q ? R_IDLE : R_WAIT;
        rerr_d = !r2_q || (PEN && rpar_q);
        rcode_d = !r2_q ? 2'b01 : rerr_d ? 2'b10 : rcode_q;
        asm_d[{rbyte_q, 3'b000} +: 8] = rsh_q;
        rbyte_d = rerr_d || rbyte_q == LAST ? '0 : rbyte_q + 1'b1;
        rvalid_d = !rerr_d && rbyte_q == LAST;
        if (rvalid_d) rdata_d = asm_d;
      end
      R_WAIT: begin
        rcnt_d = '0;
        if (r2_q) rxs_d = R_IDLE;
      end
      default: rxs_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {r1_q, r2_q, r3_q} <= 3'b111;
      rxs_q <= R_IDLE;
      rcnt_q <= '0;
      rbit_q <= '0;
      rbyte_q <= '0;
      rsh_q <= '0;
      rpar_q <= 1'b0;
      asm_q <= '0;
      rdata_q <= '0;
      rvalid_q <= 1'b0;
      rerr_q <= 1'b0;
      rcode_q <= '0;
      tmo_q <= '0;
    end else begin
      {r1_q, r2_q, r3_q} <= {s.rxd, r1_q, r2_q};
      rxs_q <= rxs_d;
      rcnt_q <= rcnt_d;
      rbit_q <= rbit_d;
      rbyte_q <= rbyte_d;
      rsh_q <= rsh_d;
      rpar_q <= rpar_d;
      asm_q <= asm_d;
      rdata_q <= rdata_d;
      rvalid_q <= rvalid_d;
      rerr_q <= rerr_d;
      rcode_q <= rcode_d;
      tmo_q <= tmo_d;
    end
  assign s.rx_valid = rvalid_q;
  assign s.rx_data = rdata_q;
  assign s.rx_err = rerr_q;
  assign s.rx_err_code = rcode_q;
endmodule

// File: tb/tb_spart_link.sv
// tb_spart_link: cross-wired link pair plus a parity-enabled receiver driven by bit-banged frames.
module tb_spart_link;
  localparam int CPB = 16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd_tb = 1'b1;
  logic use_tb = 1'b0;
  int checks = 0;
  int errors = 0;
  int berr = 0;
  int cerr = 0;
  int cval = 0;
  logic [1:0] bcode = 2'b00;
  logic [1:0] ccode = 2'b00;
  logic [23:0] bq [$];
  spart_link_if #(.DATA_W(24)) ia ();
  spart_link_if #(.DATA_W(24)) ib ();
  spart_link_if #(.DATA_W(24)) ic ();
  assign ia.rxd = ib.txd;
  assign ib.rxd = use_tb ? rxd_tb : ia.txd;
  assign ic.rxd = rxd_tb;
  spart_link u_a (.clk(clk), .rst(rst), .s(ia));
  spart_link u_b (.clk(clk), .rst(rst), .s(ib));
  spart_link #(.PARITY_EN(1)) u_c (.clk(clk), .rst(rst), .s(ic));
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (ib.rx_valid) bq.push_back(ib.rx_data);
    if (ib.rx_err) begin
      berr++;
      bcode = ib.rx_err_code;
    end
    if (ic.rx_valid) cval++;
    if (ic.rx_err) begin
      cerr++;
      ccode = ic.rx_err_code;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic send_byte(input logic [7:0] b, input logic pen, input logic flip, input logic stop);
    logic [10:0] f;
    int n;
    f = pen ? {stop, ^b ^ flip, b, 1'b0} : {1'b0, stop, b, 1'b0};
    n = pen ? 11 : 10;
    for (int i = 0; i < n; i++) begin
      rxd_tb = f[i];
      cyc(CPB);
    end
  endtask
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [29:0] fr;
    int b0, e0, c0v, c0e, n, lows;
    {ia.send_tx, ib.send_tx, ic.send_tx} = 3'b000;
    ia.tx_data = '0;
    ib.tx_data = '0;
    ic.tx_data = '0;
    cyc(3);
    chk("rst_txd", ia.txd, 1);
    chk("rst_busy", ia.tx_busy, 0);
    chk("rst_full", ia.tx_full, 0);
    chk("rst_drop", ia.tx_drop, 0);
    chk("rst_rxv", ia.rx_valid, 0);
    chk("rst_rxd", ia.rx_data, 0);
    chk("rst_code", ia.rx_err_code, 0);
    rst = 1'b0;
    cyc(4);
    b0 = bq.size();
    ia.send_tx = 1'b1;
    ia.tx_data = 24'hBEEFDE;
    cyc(1);
    ia.send_tx = 1'b0;
    cyc(9);
    fr[0] = ia.txd;
    for (int j = 1; j < 30; j++) begin
      cyc(CPB);
      fr[j] = ia.txd;
    end
    chk("t1_frame", fr, {1'b1, 8'hBE, 1'b0, 1'b1, 8'hEF, 1'b0, 1'b1, 8'hDE, 1'b0});
    cyc(7);
    chk("t1_busy_480", ia.tx_busy, 1);
    cyc(1);
    chk("t1_busy_481", ia.tx_busy, 0);
    cyc(10);
    chk("t1_rx_count", bq.size() - b0, 1);
    chk("t1_rx_data", bq[b0], 24'hBEEFDE);
    b0 = bq.size();
    ia.send_tx = 1'b1;
    for (int w = 1; w <= 5; w++) begin
      ia.tx_data = 24'(w);
      cyc(1);
      if (w == 4) chk("t2_full_4", ia.tx_full, 0);
    end
    chk("t2_full_5", ia.tx_full, 1);
    chk("t2_drop_5", ia.tx_drop, 0);
    ia.tx_data = 24'd6;
    cyc(1);
    ia.send_tx = 1'b0;
    chk("t2_drop_6", ia.tx_drop, 1);
    cyc(1);
    chk("t2_drop_7", ia.tx_drop, 0);
    cyc(2394);
    chk("t2_busy_end", ia.tx_busy, 1);
    cyc(1);
    chk("t2_busy_low", ia.tx_busy, 0);
    cyc(20);
    chk("t2_rx_count", bq.size() - b0, 5);
    for (int i = 0; i < 5; i++) chk("t2_rx_word", bq[b0 + i], 32'(i + 1));
    c0v = cval;
    c0e = cerr;
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b1);
    cyc(4);
    chk("t4_perr_count", cerr - c0e, 1);
    chk("t4_perr_code", ccode, 2'b10);
    chk("t4_no_valid", cval - c0v, 0);
    chk("t4_data_held", ic.rx_data, 0);
    cyc(32);
    for (int i = 0; i < 3; i++) send_byte(8'hA5, 1'b1, 1'b0, 1'b1);
    cyc(4);
    chk("t4_valid", cval - c0v, 1);
    chk("t4_data", ic.rx_data, 24'hA5A5A5);
    chk("t4_err_total", cerr - c0e, 1);
    use_tb = 1'b1;
    cyc(5);
    b0 = bq.size();
    e0 = berr;
    send_byte(8'h56, 1'b0, 1'b0, 1'b1);
    send_byte(8'h34, 1'b0, 1'b0, 1'b0);
    rxd_tb = 1'b1;
    cyc(48);
    chk("t3_ferr_count", berr - e0, 1);
    chk("t3_ferr_code", bcode, 2'b01);
    chk("t3_no_valid", bq.size() - b0, 0);
    chk("t3_data_held", ib.rx_data, 24'd5);
    send_byte(8'h56, 1'b0, 1'b0, 1'b1);
    send_byte(8'h34, 1'b0, 1'b0, 1'b1);
    send_byte(8'h12, 1'b0, 1'b0, 1'b1);
    cyc(4);
    chk("t3_rx_count", bq.size() - b0, 1);
    chk("t3_rx_data", bq[b0], 24'h123456);
    chk("t3_err_total", berr - e0, 1);
    b0 = bq.size();
    e0 = berr;
    send_byte(8'h42, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!ib.rx_err && n < 1000) begin
      cyc(1);
      n++;
    end
    chk("t5_tmo_latency", n, 315);
    chk("t5_tmo_code", ib.rx_err_code, 2'b11);
    cyc(20);
    send_byte(8'hFF, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    send_byte(8'h00, 1'b0, 1'b0, 1'b1);
    cyc(4);
    chk("t5_rx_count", bq.size() - b0, 1);
    chk("t5_rx_data", bq[b0], 24'h0000FF);
    chk("t5_err_total", berr - e0, 1);
    b0 = bq.size();
    e0 = berr;
    rxd_tb = 1'b0;
    cyc(3);
    rxd_tb = 1'b1;
    cyc(100);
    chk("t6_glitch_err", berr - e0, 0);
    chk("t6_glitch_rx", bq.size() - b0, 0);
    ia.send_tx = 1'b1;
    ia.tx_data = 24'h000000;
    cyc(3);
    ia.send_tx = 1'b0;
    cyc(50);
    chk("t6_pre_txd", ia.txd, 0);
    chk("t6_pre_busy", ia.tx_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_txd", ia.txd, 1);
    chk("t6_rst_busy", ia.tx_busy, 0);
    chk("t6_rst_full", ia.tx_full, 0);
    cyc(2);
    rst = 1'b0;
    lows = 0;
    for (int i = 0; i < 1000; i++) begin
      cyc(1);
      if (!ia.txd || ia.tx_busy) lows++;
    end
    chk("t6_quiet_after", lows, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
